// File: rtl/sc1602_text_buffer_if.sv
// Character write bus into the SC1602 text buffer.
// busy_o flags the post-reset clear, during which writes are dropped.
interface sc1602_text_buffer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy_o;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  busy_o
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output busy_o
  );
endinterface

// File: rtl/sc1602_text_buffer.sv
// 2x16 character frame buffer feeding the SC1602 driver,
// plus periodic display-shift command sequencing.
module sc1602_text_buffer #(
  parameter int unsigned SHIFT_TICKS = 13_500_000,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  sc1602_text_buffer_if.slave   wr,
  output logic [7:0]            char_o,
  input  logic                  drawing_i,
  input  logic                  ready_i,
  input  logic                  shift_en,
  input  logic                  shift_dir,
  output logic [2:0]            command_o,
  output logic                  frame_done_o
);

  localparam int PW = $clog2(SHIFT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_REL
  } st_e;

  logic [7:0]    mem_q [32];
  logic [4:0]    clr_q;
  logic          busy_q;
  logic [4:0]    rd_ptr_q;
  logic [7:0]    char_q;
  logic          frame_q;
  logic [2:0]    drw_q;
  logic [1:0]    rdy_q;
  logic [PW-1:0] pre_q;
  logic          pend_q;
  logic          pend_d;
  st_e           st_q;
  logic [2:0]    cmd_q;

  logic fall;
  logic ready_s;
  logic wrap;

  assign fall    = drw_q[2] & ~drw_q[1];
  assign ready_s = rdy_q[1];
  assign wrap    = (pre_q == PW'(SHIFT_TICKS - 1));

  // Clear sequence walks every cell once after reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      clr_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      clr_q <= clr_q + 5'd1;
      if (clr_q == 5'd31)
        busy_q <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      if (busy_q)
        mem_q[clr_q] <= BLANK_CHAR;
      else if (wr.wr_en)
        mem_q[wr.wr_addr] <= wr.wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      drw_q    <= '0;
      rdy_q    <= '0;
      rd_ptr_q <= '0;
      char_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      drw_q   <= {drw_q[1:0], drawing_i};
      rdy_q   <= {rdy_q[0], ready_i};
      char_q  <= mem_q[rd_ptr_q];
      frame_q <= 1'b0;
      if (fall && !busy_q) begin
        rd_ptr_q <= rd_ptr_q + 5'd1;
        frame_q  <= (rd_ptr_q == 5'd31);
      end
    end
  end

  // A wrap on the accept cycle wins, so that request is kept.
  always_comb begin
    pend_d = pend_q;
    if (st_q == ST_ISSUE && !ready_s)
      pend_d = 1'b0;
    if (wrap && shift_en)
      pend_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pre_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      pre_q  <= wrap ? '0 : pre_q + PW'(1);
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      st_q  <= ST_IDLE;
      cmd_q <= '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (pend_q && ready_s) begin
            st_q  <= ST_ISSUE;
            cmd_q <= {2'b01, shift_dir};
          end
        end
        ST_ISSUE: begin
          if (!ready_s) begin
            st_q  <= ST_REL;
            cmd_q <= '0;
          end
        end
        ST_REL: begin
          if (ready_s)
            st_q <= ST_IDLE;
        end
        default: begin
          st_q  <= ST_IDLE;
          cmd_q <= '0;
        end
      endcase
    end
  end

  assign wr.busy_o     = busy_q;
  assign char_o        = char_q;
  assign command_o     = cmd_q;
  assign frame_done_o  = frame_q;

endmodule
